regfile_sp_param: RTL and testbench

Parametrised general-purpose register file with a built-in stack pointer. It replaces the fixed 4×8 register file in the decode/write-back stage of the 8-bit pipelined processor. It generalises data width and depth, adds both push (decrement) and pop (increment) stack-pointer updates, and adds sticky overflow/underflow flags. An optional write-through bypass lets decode read a value in the same cycle that write-back writes it.

---
 rtl/regfile_sp_param_if.sv | 38 +++
 rtl/regfile_sp_param.sv | 87 ++++++++
 tb/tb_regfile_sp_param.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sp_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sp_param_if
//  Brief    : Bus bundle for the stack-pointer register file: two read ports,
//             one write port, stack-pointer controls and status outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_sp_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wdata;
  logic              wr_en;
  logic              sp_inc;
  logic              sp_dec;
  logic              clr_flags;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] sp;
  logic              sp_ovf;
  logic              sp_unf;

  // Requester side (decode / write-back logic)
  modport master (
    output ra, rb, wa, wdata, wr_en, sp_inc, sp_dec, clr_flags,
    input  rd1, rd2, sp, sp_ovf, sp_unf
  );

  // Register file side
  modport slave (
    input  ra, rb, wa, wdata, wr_en, sp_inc, sp_dec, clr_flags,
    output rd1, rd2, sp, sp_ovf, sp_unf
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sp_param.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sp_param
//  Brief    : Parametrised register file with one register doubling as a
//             stack pointer (push/pop with sticky wrap flags) and optional
//             write-through forwarding on both read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sp_param #(
  parameter int              DATA_W = 8,
  parameter int              ADDR_W = 2,
  parameter int              SP_IDX = (1 << ADDR_W) - 1,
  parameter logic [DATA_W-1:0] SP_RST = {DATA_W{1'b1}},
  parameter bit              BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_sp_param_if.slave    rf_if
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] C_SP_ADDR = ADDR_W'(SP_IDX);
  localparam logic [DATA_W-1:0] C_SP_MAX  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] C_ONE     = DATA_W'(1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] w_sp_cur;
  logic              w_sp_wr;

  assign w_sp_cur = regs_q[C_SP_ADDR];
  assign w_sp_wr  = rf_if.wr_en && (rf_if.wa == C_SP_ADDR);

  // Stack-pointer next value and flag update: explicit write beats inc/dec,
  // simultaneous inc+dec cancel, and a wrap in the same cycle beats clear.
  always_comb begin
    sp_d  = w_sp_cur;
    ovf_d = ovf_q & ~rf_if.clr_flags;
    unf_d = unf_q & ~rf_if.clr_flags;
    if (w_sp_wr) begin
      sp_d = rf_if.wdata;
    end else if (rf_if.sp_inc && !rf_if.sp_dec) begin
      sp_d = w_sp_cur + C_ONE;
      if (w_sp_cur == C_SP_MAX) ovf_d = 1'b1;
    end else if (rf_if.sp_dec && !rf_if.sp_inc) begin
      sp_d = w_sp_cur - C_ONE;
      if (w_sp_cur == '0) unf_d = 1'b1;
    end
  end

  // Register array and flags; the stack-pointer slot always takes sp_d.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i != SP_IDX) && rf_if.wr_en && (rf_if.wa == ADDR_W'(i))) begin
          regs_q[i] <= rf_if.wdata;
        end
      end
      regs_q[C_SP_ADDR] <= sp_d;
      ovf_q             <= ovf_d;
      unf_q             <= unf_d;
    end
  end

  // Read ports: forwarding only covers explicit writes, never inc/dec results.
  if (BYPASS) begin : g_bypass
    assign rf_if.rd1 = (rf_if.wr_en && (rf_if.wa == rf_if.ra)) ? rf_if.wdata : regs_q[rf_if.ra];
    assign rf_if.rd2 = (rf_if.wr_en && (rf_if.wa == rf_if.rb)) ? rf_if.wdata : regs_q[rf_if.rb];
  end else begin : g_no_bypass
    assign rf_if.rd1 = regs_q[rf_if.ra];
    assign rf_if.rd2 = regs_q[rf_if.rb];
  end

  assign rf_if.sp     = w_sp_cur;
  assign rf_if.sp_ovf = ovf_q;
  assign rf_if.sp_unf = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sp_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sp_param
//  Brief    : Self-checking bench for regfile_sp_param: default 8x4 with and
//             without forwarding, plus a 16-bit x 8 build with SP_RST=0x0100.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sp_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_sp_param_if #(.DATA_W(8),  .ADDR_W(2)) ifa ();
  regfile_sp_param_if #(.DATA_W(8),  .ADDR_W(2)) ifb ();
  regfile_sp_param_if #(.DATA_W(16), .ADDR_W(3)) ifc ();

  regfile_sp_param #(.DATA_W(8), .ADDR_W(2), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rf_if(ifa.slave));
  regfile_sp_param #(.DATA_W(8), .ADDR_W(2), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rf_if(ifb.slave));
  regfile_sp_param #(.DATA_W(16), .ADDR_W(3), .SP_RST(16'h0100), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .rf_if(ifc.slave));

  int checks = 0;
  int errors = 0;

  // Reference state: plain integer registers and flags for each geometry.
  int m8[4];
  bit o8 = 1'b0, u8 = 1'b0;
  int m16[8];
  bit o16 = 1'b0, u16 = 1'b0;

  function automatic void upd8();
    int old;
    bit wo, wu;
    if (!rst) begin
      foreach (m8[i]) m8[i] = 0;
      m8[3] = 255; o8 = 1'b0; u8 = 1'b0;
      return;
    end
    old = m8[3]; wo = 1'b0; wu = 1'b0;
    if (ifa.wr_en) m8[ifa.wa] = int'(ifa.wdata);
    if (!(ifa.wr_en && ifa.wa == 2'd3) && (ifa.sp_inc != ifa.sp_dec)) begin
      if (ifa.sp_inc) begin m8[3] = (old + 1) % 256;   wo = (old == 255); end
      else            begin m8[3] = (old + 255) % 256; wu = (old == 0);   end
    end
    o8 = (o8 && !ifa.clr_flags) || wo;
    u8 = (u8 && !ifa.clr_flags) || wu;
  endfunction

  function automatic void upd16();
    int old;
    bit wo, wu;
    if (!rst) begin
      foreach (m16[i]) m16[i] = 0;
      m16[7] = 256; o16 = 1'b0; u16 = 1'b0;
      return;
    end
    old = m16[7]; wo = 1'b0; wu = 1'b0;
    if (ifc.wr_en) m16[ifc.wa] = int'(ifc.wdata);
    if (!(ifc.wr_en && ifc.wa == 3'd7) && (ifc.sp_inc != ifc.sp_dec)) begin
      if (ifc.sp_inc) begin m16[7] = (old + 1) % 65536;     wo = (old == 65535); end
      else            begin m16[7] = (old + 65535) % 65536; wu = (old == 0);     end
    end
    o16 = (o16 && !ifc.clr_flags) || wo;
    u16 = (u16 && !ifc.clr_flags) || wu;
  endfunction

  // One clock edge: advance the models with the inputs sampled at that edge.
  task automatic tick();
    @(posedge clk);
    upd8();
    upd16();
    #1;
  endtask

  // Drive both 8-bit DUTs with identical inputs.
  task automatic drv8(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] wa,
                      input logic [7:0] wd, input logic we, input logic inc,
                      input logic dec, input logic clr);
    ifa.ra = ra; ifa.rb = rb; ifa.wa = wa; ifa.wdata = wd;
    ifa.wr_en = we; ifa.sp_inc = inc; ifa.sp_dec = dec; ifa.clr_flags = clr;
    ifb.ra = ra; ifb.rb = rb; ifb.wa = wa; ifb.wdata = wd;
    ifb.wr_en = we; ifb.sp_inc = inc; ifb.sp_dec = dec; ifb.clr_flags = clr;
  endtask

  task automatic idle();
    drv8(2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    ifc.ra = '0; ifc.rb = '0; ifc.wa = '0; ifc.wdata = '0;
    ifc.wr_en = 1'b0; ifc.sp_inc = 1'b0; ifc.sp_dec = 1'b0; ifc.clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0]  e8;
    logic [15:0] e16;
    rst = 1'b0; idle(); tick(); rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifa.ra = 2'(i); ifa.rb = 2'(i); ifb.ra = 2'(i); ifb.rb = 2'(i);
      ifc.ra = 3'(i); ifc.rb = 3'(i);
      #1;
      if (i < 4) begin
        e8 = (i == 3) ? 8'hFF : 8'h00;
        checks++;
        if (ifa.rd1 !== e8 || ifa.rd2 !== e8 || ifb.rd1 !== e8 || ifb.rd2 !== e8) begin
          errors++;
          $display("FAIL reset_r8[%0d]: got a=%h/%h b=%h/%h expected %h", i, ifa.rd1, ifa.rd2, ifb.rd1, ifb.rd2, e8);
        end
      end
      e16 = (i == 7) ? 16'h0100 : 16'h0000;
      checks++;
      if (ifc.rd1 !== e16 || ifc.rd2 !== e16) begin
        errors++;
        $display("FAIL reset_r16[%0d]: got %h/%h expected %h", i, ifc.rd1, ifc.rd2, e16);
      end
    end
    checks++;
    if (ifa.sp !== 8'hFF || ifa.sp_ovf !== 1'b0 || ifa.sp_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_sp8: got sp=%h ovf=%b unf=%b expected sp=ff ovf=0 unf=0", ifa.sp, ifa.sp_ovf, ifa.sp_unf);
    end
    checks++;
    if (ifc.sp !== 16'h0100 || ifc.sp_ovf !== 1'b0 || ifc.sp_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_sp16: got sp=%h ovf=%b unf=%b expected sp=0100 ovf=0 unf=0", ifc.sp, ifc.sp_ovf, ifc.sp_unf);
    end
    idle();
  endtask

  task automatic test_wrap();
    drv8(2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick(); idle();
    checks++;
    if (ifa.sp !== 8'h00 || ifa.sp_ovf !== 1'b1 || ifb.sp !== 8'h00 || ifb.sp_ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_inc: got sp=%h ovf=%b expected sp=00 ovf=1", ifa.sp, ifa.sp_ovf);
    end
    drv8(2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); tick(); idle();
    checks++;
    if (ifa.sp !== 8'hFF || ifa.sp_unf !== 1'b1 || ifa.sp_ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_dec: got sp=%h ovf=%b unf=%b expected sp=ff ovf=1 unf=1", ifa.sp, ifa.sp_ovf, ifa.sp_unf);
    end
    drv8(2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick(); idle();
    checks++;
    if (ifa.sp_ovf !== 1'b0 || ifa.sp_unf !== 1'b0 || ifa.sp !== 8'hFF) begin
      errors++;
      $display("FAIL clr_flags: got sp=%h ovf=%b unf=%b expected sp=ff ovf=0 unf=0", ifa.sp, ifa.sp_ovf, ifa.sp_unf);
    end
    // Clear and a fresh wrap in the same cycle: the flag must end up set.
    drv8(2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1); tick(); idle();
    checks++;
    if (ifa.sp_ovf !== 1'b1 || ifa.sp !== 8'h00) begin
      errors++;
      $display("FAIL clr_vs_wrap: got sp=%h ovf=%b expected sp=00 ovf=1", ifa.sp, ifa.sp_ovf);
    end
    drv8(2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); tick(); idle();
  endtask

  task automatic test_priority();
    drv8(2'd0, 2'd0, 2'd3, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0); tick(); idle();
    checks++;
    if (ifa.sp !== 8'h40 || ifa.sp_ovf !== 1'b0 || ifa.sp_unf !== 1'b0) begin
      errors++;
      $display("FAIL prio_write: got sp=%h ovf=%b unf=%b expected sp=40 ovf=0 unf=0", ifa.sp, ifa.sp_ovf, ifa.sp_unf);
    end
    drv8(2'd0, 2'd0, 2'd3, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drv8(2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0); tick(); idle();
    checks++;
    if (ifa.sp !== 8'h10 || ifb.sp !== 8'h10) begin
      errors++;
      $display("FAIL prio_inc_dec: got sp=%h expected 10", ifa.sp);
    end
  endtask

  task automatic test_bypass();
    drv8(2'd0, 2'd0, 2'd1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drv8(2'd1, 2'd1, 2'd1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (ifa.rd1 !== 8'hA5 || ifa.rd2 !== 8'hA5) begin
      errors++;
      $display("FAIL bypass_on: got %h/%h expected a5/a5", ifa.rd1, ifa.rd2);
    end
    checks++;
    if (ifb.rd1 !== 8'h5A || ifb.rd2 !== 8'h5A) begin
      errors++;
      $display("FAIL bypass_off: got %h/%h expected 5a/5a", ifb.rd1, ifb.rd2);
    end
    tick();
    drv8(2'd1, 2'd1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (ifb.rd1 !== 8'hA5 || ifb.rd2 !== 8'hA5) begin
      errors++;
      $display("FAIL bypass_off_next: got %h/%h expected a5/a5", ifb.rd1, ifb.rd2);
    end
    // A same-cycle pop is not forwarded on a read of the stack-pointer slot.
    drv8(2'd3, 2'd3, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    checks++;
    if (ifa.rd1 !== 8'h10 || ifa.rd2 !== 8'h10) begin
      errors++;
      $display("FAIL sp_no_fwd: got %h/%h expected 10/10", ifa.rd1, ifa.rd2);
    end
    tick(); idle();
    checks++;
    if (ifa.sp !== 8'h11) begin
      errors++;
      $display("FAIL sp_pop: got %h expected 11", ifa.sp);
    end
  endtask

  task automatic test_concurrent();
    drv8(2'd0, 2'd0, 2'd3, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drv8(2'd0, 2'd0, 2'd2, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drv8(2'd2, 2'd2, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (ifa.rd1 !== 8'h33 || ifb.rd2 !== 8'h33 || ifa.sp !== 8'h7F) begin
      errors++;
      $display("FAIL concurrent: got r2=%h/%h sp=%h expected r2=33 sp=7f", ifa.rd1, ifb.rd2, ifa.sp);
    end
    idle();
  endtask

  task automatic test_reset_inflight();
    drv8(2'd0, 2'd0, 2'd1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0; tick(); rst = 1'b1; idle();
    ifa.ra = 2'd1; #1;
    checks++;
    if (ifa.sp !== 8'hFF || ifa.rd1 !== 8'h00 || ifa.sp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_inflight: got sp=%h r1=%h ovf=%b expected sp=ff r1=00 ovf=0", ifa.sp, ifa.rd1, ifa.sp_ovf);
    end
  endtask

  task automatic test_sweep();
    rst = 1'b0; idle(); tick(); rst = 1'b1;
    ifc.sp_dec = 1'b1;
    repeat (256) tick();
    ifc.sp_dec = 1'b0;
    checks++;
    if (ifc.sp !== 16'h0000 || ifc.sp_unf !== 1'b0) begin
      errors++;
      $display("FAIL sweep_to_zero: got sp=%h unf=%b expected sp=0000 unf=0", ifc.sp, ifc.sp_unf);
    end
    ifc.sp_dec = 1'b1; tick(); ifc.sp_dec = 1'b0;
    checks++;
    if (ifc.sp !== 16'hFFFF || ifc.sp_unf !== 1'b1) begin
      errors++;
      $display("FAIL sweep_wrap: got sp=%h unf=%b expected sp=ffff unf=1", ifc.sp, ifc.sp_unf);
    end
    ifc.sp_inc = 1'b1; tick(); ifc.sp_inc = 1'b0;
    checks++;
    if (ifc.sp !== 16'h0000 || ifc.sp_ovf !== 1'b1 || ifc.sp_unf !== 1'b1) begin
      errors++;
      $display("FAIL sweep_ovf: got sp=%h ovf=%b unf=%b expected sp=0000 ovf=1 unf=1", ifc.sp, ifc.sp_ovf, ifc.sp_unf);
    end
  endtask

  task automatic test_random();
    logic [7:0]  e1, e2;
    logic [15:0] f1, f2;
    logic [7:0]  wd8;
    logic [15:0] wd16;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      case ($urandom_range(0, 3))
        0: wd8 = 8'h00;
        1: wd8 = 8'hFF;
        default: wd8 = 8'($urandom);
      endcase
      drv8(2'($urandom), 2'($urandom), 2'($urandom), wd8, 1'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      case ($urandom_range(0, 3))
        0: wd16 = 16'h0000;
        1: wd16 = 16'hFFFF;
        default: wd16 = 16'($urandom);
      endcase
      ifc.ra = 3'($urandom); ifc.rb = 3'($urandom); ifc.wa = 3'($urandom);
      ifc.wdata = wd16; ifc.wr_en = 1'($urandom); ifc.sp_inc = 1'($urandom);
      ifc.sp_dec = 1'($urandom); ifc.clr_flags = ($urandom_range(0, 7) == 0);
      #1;
      e1 = (ifa.wr_en && ifa.wa == ifa.ra) ? ifa.wdata : 8'(m8[ifa.ra]);
      e2 = (ifa.wr_en && ifa.wa == ifa.rb) ? ifa.wdata : 8'(m8[ifa.rb]);
      checks++;
      if (ifa.rd1 !== e1 || ifa.rd2 !== e2) begin
        errors++;
        $display("FAIL rand_read_a[%0d]: got %h/%h expected %h/%h", n, ifa.rd1, ifa.rd2, e1, e2);
      end
      checks++;
      if (ifb.rd1 !== 8'(m8[ifb.ra]) || ifb.rd2 !== 8'(m8[ifb.rb])) begin
        errors++;
        $display("FAIL rand_read_b[%0d]: got %h/%h expected %h/%h", n, ifb.rd1, ifb.rd2, 8'(m8[ifb.ra]), 8'(m8[ifb.rb]));
      end
      f1 = (ifc.wr_en && ifc.wa == ifc.ra) ? ifc.wdata : 16'(m16[ifc.ra]);
      f2 = (ifc.wr_en && ifc.wa == ifc.rb) ? ifc.wdata : 16'(m16[ifc.rb]);
      checks++;
      if (ifc.rd1 !== f1 || ifc.rd2 !== f2) begin
        errors++;
        $display("FAIL rand_read_c[%0d]: got %h/%h expected %h/%h", n, ifc.rd1, ifc.rd2, f1, f2);
      end
      tick();
      checks++;
      if (ifa.sp !== 8'(m8[3]) || ifa.sp_ovf !== o8 || ifa.sp_unf !== u8 ||
          ifb.sp !== 8'(m8[3]) || ifb.sp_ovf !== o8 || ifb.sp_unf !== u8) begin
        errors++;
        $display("FAIL rand_sp8[%0d]: got sp=%h ovf=%b unf=%b expected sp=%h ovf=%b unf=%b",
                 n, ifa.sp, ifa.sp_ovf, ifa.sp_unf, 8'(m8[3]), o8, u8);
      end
      checks++;
      if (ifc.sp !== 16'(m16[7]) || ifc.sp_ovf !== o16 || ifc.sp_unf !== u16) begin
        errors++;
        $display("FAIL rand_sp16[%0d]: got sp=%h ovf=%b unf=%b expected sp=%h ovf=%b unf=%b",
                 n, ifc.sp, ifc.sp_ovf, ifc.sp_unf, 16'(m16[7]), o16, u16);
      end
    end
    rst = 1'b1;
    idle();
  endtask

  initial begin
    foreach (m8[i])  m8[i]  = 0;
    foreach (m16[i]) m16[i] = 0;
    idle();
    test_reset();
    test_wrap();
    test_priority();
    test_bypass();
    test_concurrent();
    test_reset_inflight();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
